// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter/router: FSM states, ID width and
// the default broadcast destination.
package bus_pkg;

  localparam int ID_W  = 8;
  localparam int CNT_W = 16;

  localparam logic [ID_W-1:0] BCAST_ID_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_ROUTE = 2'd2
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: round-robin starting after the last grant,
// or fixed priority where the lowest requesting index wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  input  logic                 mode_i,
  output logic [$clog2(N)-1:0] grant_o,
  output logic                 valid_o
);

  localparam int GW = $clog2(N);

  always_comb begin : search
    int idx;
    // NOTE: every output and local gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    if (mode_i) begin
      for (int off = 1; off <= N; off++) begin
        idx = int'(last_i) + off;
        if (idx >= N) idx = idx - N;
        if (!valid_o && req_i[idx]) begin
          grant_o = GW'(idx);
          valid_o = 1'b1;
        end
      end
    end else begin
      // Walk downward so the last hit, the lowest index, is the one kept.
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          grant_o = GW'(i);
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arb_router.sv
// Arbitrated packet router: one driver is granted, its head packet popped one
// cycle later and pushed to the destination driver(s) the cycle after that.
module bus_arb_router
  import bus_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID_DEFAULT,
  parameter int              rr_mode   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [drvrs-1:0]              pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]              pop,
  output logic [drvrs-1:0]              push,
  output logic [drvrs-1:0][pckg_sz-1:0] D_push,
  output logic                          busy,
  output logic [$clog2(drvrs)-1:0]      grant_id,
  output logic [CNT_W-1:0]              drop_cnt
);

  localparam int GW = $clog2(drvrs);

  state_e                        state_q;
  logic [drvrs-1:0]              pop_q;
  logic [drvrs-1:0]              push_q;
  logic [drvrs-1:0][pckg_sz-1:0] d_push_q;
  logic                          busy_q;
  logic [GW-1:0]                 grant_q;
  logic [GW-1:0]                 rr_last_q;
  logic [pckg_sz-1:0]            pkt_q;
  logic [CNT_W-1:0]              drop_cnt_q;

  logic [GW-1:0]    arb_grant;
  logic             arb_valid;
  logic [ID_W-1:0]  dest;
  logic [GW-1:0]    dest_idx;
  logic             dest_in_range;
  logic [drvrs-1:0] route_mask_d;
  logic             drop_d;

  rr_arbiter #(
    .N (drvrs)
  ) u_arb (
    .req_i   (pndng),
    .last_i  (rr_last_q),
    .mode_i  (rr_mode != 0),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  // Destination decode of the captured packet; an empty mask means drop.
  assign dest          = pkt_q[pckg_sz-1 -: ID_W];
  assign dest_idx      = dest[GW-1:0];
  assign dest_in_range = int'(dest) < drvrs;

  always_comb begin
    route_mask_d = '0;
    if (dest == broadcast) begin
      route_mask_d           = '1;
      route_mask_d[grant_q]  = 1'b0;
    end else if (dest_in_range && (dest_idx != grant_q)) begin
      route_mask_d[dest_idx] = 1'b1;
    end
  end

  assign drop_d = (route_mask_d == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pop_q      <= '0;
      push_q     <= '0;
      d_push_q   <= '0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      rr_last_q  <= GW'(drvrs - 1);
      // NOTE: the packet register is reset on purpose so a packet caught
      // mid-flight can never reappear after reset is released.
      pkt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      pop_q    <= '0;
      push_q   <= '0;
      d_push_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q   <= arb_grant;
            rr_last_q <= arb_grant;
            busy_q    <= 1'b1;
            state_q   <= ST_POP;
          end
        end
        ST_POP: begin
          // The FIFO may have emptied since the grant; abandon quietly.
          if (pndng[grant_q]) begin
            pop_q[grant_q] <= 1'b1;
            pkt_q          <= D_pop[grant_q];
            state_q        <= ST_ROUTE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ROUTE: begin
          push_q <= route_mask_d;
          for (int d = 0; d < drvrs; d++) begin
            if (route_mask_d[d]) d_push_q[d] <= pkt_q;
          end
          if (drop_d) drop_cnt_q <= sat_inc(drop_cnt_q);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign drop_cnt = drop_cnt_q;

  a_pop_push_excl : assert property (@(posedge clk) disable iff (reset)
    !((|pop) && (|push)));
  a_pop_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(pop));

endmodule

// File: doc/bus_arb_router.md
BUS_ARB_ROUTER -- requirements
Module: bus_arb_router

Interface
REQ-001 SHALL have parameter drvrs, default 4: number of driver ports, 2..16.
REQ-002 SHALL have parameter pckg_sz, default 16: packet width in bits, minimum 12.
REQ-003 SHALL have parameter broadcast, default 8'hFF: destination ID that delivers to all drivers except the source.
REQ-004 SHALL have parameter rr_mode, default 1: 1 selects round-robin grant, 0 selects fixed priority (lowest index wins).
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pndng, input, [drvrs-1:0]: driver d's FIFO is non-empty.
REQ-008 SHALL have port D_pop, input, [drvrs-1:0][pckg_sz-1:0]: head-of-FIFO packet per driver.
REQ-009 SHALL have port pop, output, [drvrs-1:0]: one-cycle pop strobe per driver.
REQ-010 SHALL have port push, output, [drvrs-1:0]: one-cycle push strobe per destination.
REQ-011 SHALL have port D_push, output, [drvrs-1:0][pckg_sz-1:0]: packet presented with push.
REQ-012 SHALL have port busy, output, 1 bit: FSM is not in IDLE.
REQ-013 SHALL have port grant_id, output, [$clog2(drvrs)-1:0]: last granted driver.
REQ-014 SHALL have port drop_cnt, output, 16 bits: saturating count of dropped packets.

Function
REQ-015 SHALL treat D_pop[d][pckg_sz-1 -: 8] as the destination ID; the remaining bits are payload.
REQ-016 SHALL implement FSM IDLE -> POP -> ROUTE -> IDLE; all outputs are registered.
REQ-017 In IDLE, if any pndng bit is sampled high, SHALL select grant g, update grant_id, and enter POP.
REQ-018 In POP, if pndng[g] is still high, SHALL assert pop[g] for exactly one cycle and capture D_pop[g]; otherwise SHALL return to IDLE without popping.
REQ-019 In ROUTE, SHALL assert push[dest] for one cycle with D_push[dest] equal to the captured packet, then return to IDLE.
REQ-020 For broadcast, SHALL assert push on every driver except g in the same cycle, all carrying the same packet.
REQ-021 SHALL drop, without any push, a packet whose destination is >= drvrs and != broadcast, or equal to g; drop_cnt increments by 1 and saturates at 16'hFFFF.
REQ-022 Latency: pndng high at edge N -> pop at cycle N+1 -> push at cycle N+2; at most one packet per 3 cycles.
REQ-023 In round-robin mode, SHALL search from (last g + 1) mod drvrs upward with wrap-around; in fixed mode, SHALL grant the lowest pending index.
REQ-024 SHALL drive D_push ports with push low to 0.
REQ-025 SHALL keep pop and push at most one-hot per driver bit for exactly one cycle; they are never asserted in the same cycle.

Reset
REQ-026 Reset assertion SHALL immediately force state IDLE, pop=0, push=0, D_push=0, busy=0, grant_id=0, drop_cnt=0, and the round-robin pointer to drvrs-1, so the first grant goes to 0.
REQ-027 Reset mid-operation SHALL discard the captured packet, with no push after deassertion.

Structure
REQ-028 Package bus_pkg SHALL hold the FSM state enum, the ID width constant (8), and the default broadcast ID.
REQ-029 Grant selection SHALL live in sub-module rr_arbiter (inputs: req, last grant, mode; output: grant index and valid).

Verification (drvrs=4, pckg_sz=16)
REQ-030 After reset, driver 0 has pndng=1, D_pop=16'h0212 -> pop[0] asserted one cycle later; push[2]=1 and D_push[2]=16'h0212 the following cycle.
REQ-031 All four pndng held high, each packet valid -> grants follow 0,1,2,3,0; with rr_mode=0, grants are always 0.
REQ-032 Driver 1 sends 16'hFFAB -> push=4'b1101 in a single cycle, each with 16'hFFAB.
REQ-033 Driver 3 sends 16'h0700, then 16'h0300 -> no push for either; drop_cnt=2.
REQ-034 Reset asserted during ROUTE -> push=0 immediately; no push occurs after release; grant_id=0.
REQ-035 pndng[2] drops in the cycle after grant -> no pop, FSM returns to IDLE, drop_cnt unchanged.
